// File: rtl/alu_share_seq.sv
// Shares one external ALU between two requesters: round-robin grant, fixed-latency
// issue, result capture and a single tagged response channel with error screening.
module alu_share_seq #(
  parameter int DATA_W  = 16,
  parameter int RES_W   = 15,
  parameter int CMD_W   = 3,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CMD_W-1:0]  alu_cmd,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        lat_cnt;
  logic              last_grant;
  logic              grant;
  logic              accept;
  logic              sel_err;
  logic [CMD_W-1:0]  sel_cmd;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // Alternate only under contention; a lone requester always wins.
  assign grant  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign accept = (state == IDLE) && (req0_valid || req1_valid);

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign rsp_valid  = (state == RESP);

  assign sel_cmd = grant ? req1_cmd : req0_cmd;
  assign sel_a   = grant ? req1_a   : req0_a;
  assign sel_b   = grant ? req1_b   : req0_b;

  // Divide on a zero magnitude field (bit 0 is not part of the magnitude) or unused code.
  assign sel_err = (((sel_cmd == CMD_W'(5)) || (sel_cmd == CMD_W'(6))) &&
                    (sel_b[DATA_W-1:1] == '0)) ||
                   (sel_cmd == CMD_W'(7));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sel_err ? RESP : ISSUE;
      ISSUE:   if (lat_cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cmd    <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      lat_cnt    <= 4'd0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_cmd    <= sel_cmd;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            rsp_id     <= grant;
            last_grant <= grant;
            rsp_err    <= sel_err;
            rsp_result <= '0;
            lat_cnt    <= 4'(ALU_LAT - 1);
          end
        end
        ISSUE: begin
          if (lat_cnt == 4'd0) rsp_result <= alu_result;
          else                 lat_cnt    <= lat_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
